ps2_rx_controller: RTL and testbench

//   Sequences reception of one PS/2 device-to-host frame in the system clock domain.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_rx_controller.sv | 135 +++++++++++++
 tb/tb_ps2_rx_controller.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_rx_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    // A valid frame carries an odd number of ones across data and parity.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pin synchroniser plus run-length glitch filter for one PS/2 line.
// level changes only after FILTER_LEN consecutive differing samples; fall strobes with it.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          run_cnt;
    logic                   sampled;

    assign sampled = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync    <= '1;
            run_cnt <= '0;
            level   <= 1'b1;
            fall    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            fall <= 1'b0;
            if (sampled == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                // This is the FILTER_LEN-th differing sample in a row.
                level   <= sampled;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 device-to-host frame receiver: filtered pins, frame FSM, bit counter,
// inactivity timer and a valid/ack holding register for the scan-code decoder.
module ps2_rx_controller
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2c,
    input  logic                     ps2d,
    input  logic                     rx_en,
    input  logic                     rx_ack,
    output logic [PS2_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_rx_state_t             state;
    logic [3:0]                bit_cnt;
    logic [PS2_FRAME_BITS-2:0] sr;
    logic [TW-1:0]             timer;

    logic c_fall;
    logic c_level_unused;
    logic ps2d_s;
    logic d_fall_unused;

    ps2_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .reset(reset),
        .pin  (ps2c),
        .level(c_level_unused),
        .fall (c_fall)
    );

    ps2_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_data_filter (
        .clk  (clk),
        .reset(reset),
        .pin  (ps2d),
        .level(ps2d_s),
        .fall (d_fall_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            timer      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // A fall with data high is line noise, not a start bit.
                    if (c_fall && rx_en && !ps2d_s) begin
                        state   <= RECV;
                        busy    <= 1'b1;
                        bit_cnt <= 4'(PS2_FRAME_BITS - 1);
                        timer   <= '0;
                    end
                end

                RECV: begin
                    if (!rx_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (c_fall) begin
                        sr      <= {ps2d_s, sr[PS2_FRAME_BITS-2:1]};
                        bit_cnt <= bit_cnt - 4'd1;
                        timer   <= '0;
                        if (bit_cnt == 4'd1) begin
                            state <= CHECK;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (rx_en) begin
                        if (!sr[PS2_FRAME_BITS-2]) begin
                            frame_err <= 1'b1;
                        end else if (!odd_parity_ok(sr[PS2_DATA_BITS-1:0], sr[PS2_DATA_BITS])) begin
                            parity_err <= 1'b1;
                        end else if (rx_valid && !rx_ack) begin
                            overrun <= 1'b1;
                        end else begin
                            // An ack in this same cycle frees the register for the new byte.
                            rx_data  <= sr[PS2_DATA_BITS-1:0];
                            rx_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Self-checking bench for ps2_rx_controller: directed scenarios plus randomized frames
// checked against a frame-level model with a one-entry expected-byte queue.
module tb_ps2_rx_controller;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int HALF           = 40;
    // Clock edges from a pin change to the filtered fall strobe.
    localparam int LAT            = SYNC_STAGES + FILTER_LEN;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       ps2c   = 1'b1;
    logic       ps2d   = 1'b1;
    logic       rx_en  = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc            = 0;
    int n_par          = 0;
    int n_frm          = 0;
    int n_ovr          = 0;
    int frm_cyc        = -1;
    int valid_rise_cyc = -1;
    int last_fall_cyc  = 0;
    logic valid_q      = 1'b0;

    logic [7:0] exp_q[$];

    ps2_rx_controller #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rx_en     (rx_en),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (parity_err) n_par++;
        if (frame_err) begin
            n_frm++;
            frm_cyc = cyc;
        end
        if (overrun) n_ovr++;
        if (rx_valid && !valid_q) valid_rise_cyc = cyc;
        valid_q = rx_valid;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog cycles %0d limit 95000", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // 0 = good byte, 1 = parity error, 2 = frame error, 3 = overrun
    function automatic int predict(input logic [7:0] d, input logic p, input logic stop,
                                   input bit held, input bit ack);
        if (stop == 1'b0) return 2;
        if ((($countones(d) + int'(p)) % 2) == 0) return 1;
        if (held && !ack) return 3;
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input bit glitch, input bit ack_check);
        ps2d = b;
        if (glitch) begin
            repeat (10) @(negedge clk);
            ps2c = 1'b0;
            repeat (7) @(negedge clk);
            ps2c = 1'b1;
            repeat (HALF - 17) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2c = 1'b0;
        last_fall_cyc = cyc;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (ack_check && i == LAT + 1) rx_ack = 1'b1;
            if (ack_check && i == LAT + 2) rx_ack = 1'b0;
        end
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int nbits, input int glitch_idx, input bit ack_check);
        logic [10:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i], i == glitch_idx, ack_check && i == 10);
        end
        ps2d = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data got %h exp 00", rx_data);
        end
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid_busy got %b exp 00", {rx_valid, busy});
        end
        checks++;
        if ({parity_err, frame_err, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 000", {parity_err, frame_err, overrun});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int p0, f0, o0;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        valid_rise_cyc = -1;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
        exp_q.push_back(8'h1C);
        checks++;
        if (valid_rise_cyc - last_fall_cyc != LAT + 2) begin
            errors++;
            $display("FAIL good_latency got %0d exp %0d", valid_rise_cyc - last_fall_cyc, LAT + 2);
        end
        checks++;
        if (rx_data !== exp_q[0] || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL good_data got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        checks++;
        if (n_par != p0 || n_frm != f0 || n_ovr != o0) begin
            errors++;
            $display("FAIL good_no_pulse got %0d/%0d/%0d exp 0/0/0", n_par - p0, n_frm - f0, n_ovr - o0);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL good_hold got %b exp 1", rx_valid);
        end
        do_ack();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL good_ack_clear got %b exp 0", rx_valid);
        end
    endtask

    task automatic test_errors();
        int p0, f0, o0;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 1'b0);
        checks++;
        if (n_par != p0 + 1 || n_frm != f0 || n_ovr != o0) begin
            errors++;
            $display("FAIL parity_pulse got %0d/%0d/%0d exp 1/0/0", n_par - p0, n_frm - f0, n_ovr - o0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_no_valid got %b exp 0", rx_valid);
        end
        p0 = n_par; f0 = n_frm;
        send_frame(8'h55, 1'b1, 1'b0, 11, -1, 1'b0);
        checks++;
        if (n_frm != f0 + 1 || n_par != p0 || n_ovr != o0) begin
            errors++;
            $display("FAIL stop_pulse got %0d/%0d/%0d exp 0/1/0", n_par - p0, n_frm - f0, n_ovr - o0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_valid got %b exp 0", rx_valid);
        end
    endtask

    task automatic test_timeout();
        int f0, waited;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        f0 = n_frm;
        send_frame(d, ~^d, 1'b1, 6, -1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_mid got %b exp 1", busy);
        end
        waited = 0;
        while (n_frm == f0 && waited < TIMEOUT_CYCLES + 500) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_frm != f0 + 1) begin
            errors++;
            $display("FAIL timeout_pulse got %0d exp 1", n_frm - f0);
        end
        checks++;
        if (frm_cyc - last_fall_cyc != LAT + 1 + TIMEOUT_CYCLES) begin
            errors++;
            $display("FAIL timeout_delay got %0d exp %0d", frm_cyc - last_fall_cyc, LAT + 1 + TIMEOUT_CYCLES);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy_after got %b exp 0", busy);
        end
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 1'b0);
        exp_q.push_back(8'h5A);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
            errors++;
            $display("FAIL timeout_next got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        do_ack();
    endtask

    task automatic test_overrun();
        int o0;
        send_frame(8'h12, 1'b1, 1'b1, 11, -1, 1'b0);
        exp_q.push_back(8'h12);
        o0 = n_ovr;
        send_frame(8'h34, 1'b0, 1'b1, 11, -1, 1'b0);
        checks++;
        if (n_ovr != o0 + 1) begin
            errors++;
            $display("FAIL overrun_pulse got %0d exp 1", n_ovr - o0);
        end
        checks++;
        if (rx_data !== exp_q[0] || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_keep got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        do_ack();
        send_frame(8'h12, 1'b1, 1'b1, 11, -1, 1'b0);
        exp_q.push_back(8'h12);
        o0 = n_ovr;
        send_frame(8'h34, 1'b0, 1'b1, 11, -1, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h34);
        checks++;
        if (n_ovr != o0) begin
            errors++;
            $display("FAIL ack_check_no_overrun got %0d exp 0", n_ovr - o0);
        end
        checks++;
        if (rx_data !== exp_q[0] || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_check_load got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        do_ack();
    endtask

    task automatic test_glitch();
        int p0, f0, o0;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        @(negedge clk);
        ps2c = 1'b0;
        repeat (7) @(negedge clk);
        ps2c = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_par != p0 || n_frm != f0 || n_ovr != o0) begin
            errors++;
            $display("FAIL glitch_idle got busy %b pulses %0d/%0d/%0d exp 0 0/0/0",
                     busy, n_par - p0, n_frm - f0, n_ovr - o0);
        end
        send_frame(8'hA5, 1'b1, 1'b1, 11, 4, 1'b0);
        exp_q.push_back(8'hA5);
        checks++;
        if (rx_data !== exp_q[0] || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL glitch_recv got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        checks++;
        if (n_par != p0 || n_frm != f0 || n_ovr != o0) begin
            errors++;
            $display("FAIL glitch_no_pulse got %0d/%0d/%0d exp 0/0/0", n_par - p0, n_frm - f0, n_ovr - o0);
        end
        do_ack();
    endtask

    task automatic test_abort();
        int p0, f0, o0;
        logic [7:0] d;
        p0 = n_par; f0 = n_frm; o0 = n_ovr;
        d = 8'($urandom_range(0, 255));
        send_frame(d, ~^d, 1'b1, 4, -1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before got %b exp 1", busy);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got busy %b valid %b exp 0 0", busy, rx_valid);
        end

        d = 8'($urandom_range(0, 255));
        send_frame(d, ~^d, 1'b1, 11, -1, 1'b0);
        exp_q.push_back(d);
        send_frame(8'h3C, 1'b1, 1'b1, 4, -1, 1'b0);
        rx_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_en_busy got %b exp 0", busy);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
            errors++;
            $display("FAIL abort_en_held got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        checks++;
        if (n_par != p0 || n_frm != f0 || n_ovr != o0) begin
            errors++;
            $display("FAIL abort_no_pulse got %0d/%0d/%0d exp 0/0/0", n_par - p0, n_frm - f0, n_ovr - o0);
        end
        rx_en = 1'b1;
        do_ack();
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
        exp_q.push_back(8'h1C);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
            errors++;
            $display("FAIL abort_next got %h/%b exp %h/1", rx_data, rx_valid, exp_q[0]);
        end
        do_ack();
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int p0, f0, o0, outcome;
            logic [7:0] d;
            logic p, stop;
            bit ack_chk, held;
            logic [2:0] exp_pulses, got_pulses;
            if ($urandom_range(0, 1) == 1) do_ack();
            d       = 8'($urandom_range(0, 255));
            p       = ($urandom_range(0, 3) == 0) ? ^d : ~^d;
            stop    = ($urandom_range(0, 4) != 0);
            ack_chk = ($urandom_range(0, 2) == 0);
            held    = (exp_q.size() != 0);
            outcome = predict(d, p, stop, held, ack_chk);
            p0 = n_par; f0 = n_frm; o0 = n_ovr;
            send_frame(d, p, stop, 11, -1, ack_chk);
            if (held && ack_chk) void'(exp_q.pop_front());
            if (outcome == 0) exp_q.push_back(d);
            exp_pulses = {outcome == 1, outcome == 2, outcome == 3};
            got_pulses = {3'(n_par - p0), 3'(n_frm - f0), 3'(n_ovr - o0)} == 9'd0 ? 3'b000 :
                         {n_par - p0 == 1, n_frm - f0 == 1, n_ovr - o0 == 1};
            checks++;
            if (got_pulses !== exp_pulses || (n_par - p0) + (n_frm - f0) + (n_ovr - o0) > 1) begin
                errors++;
                $display("FAIL rand_pulses frame %0d got %0d/%0d/%0d exp %b", n,
                         n_par - p0, n_frm - f0, n_ovr - o0, exp_pulses);
            end
            checks++;
            if (rx_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid frame %0d got %b exp %b", n, rx_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (rx_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand_data frame %0d got %h exp %h", n, rx_data, exp_q[0]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_timeout();
        test_overrun();
        test_glitch();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
